// File: rtl/fft2048_pkg.sv
`default_nettype none
// ============================================================================
// fft2048_pkg : shared constants, types and butterfly address helper
//               for the 2048-point radix-2 DIT FFT.
// Revision    : 1.0
// ============================================================================
package fft2048_pkg;

    localparam int LOG2N      = 11;
    localparam int N          = 1 << LOG2N;
    localparam int NBFLY      = N / 2;
    localparam int NSTAGE     = LOG2N;
    localparam int TOTAL_BFLY = NBFLY * NSTAGE;

    localparam int AW = LOG2N;
    localparam int TW = LOG2N - 1;
    localparam int KW = LOG2N - 1;
    localparam int SW = 4;

    typedef struct packed {
        logic [AW-1:0] addr_a;
        logic [AW-1:0] addr_b;
        logic [TW-1:0] twiddle;
    } bfly_addr_t;

    // Upper/lower RAM addresses insert a zero at bit s of k; the twiddle index
    // is the in-group offset scaled up to the full-length ROM.
    function automatic bfly_addr_t bfly_addr(input logic [KW-1:0] k, input logic [SW-1:0] s);
        logic [AW-1:0] kk;
        logic [AW-1:0] half;
        logic [AW-1:0] mask;
        logic [SW-1:0] tw_shift;
        bfly_addr_t    r;
        kk        = {1'b0, k};
        half      = AW'(1) << s;
        mask      = half - AW'(1);
        tw_shift  = SW'(LOG2N - 1) - s;
        r.addr_a  = (((kk >> s) << 1) << s) | (kk & mask);
        r.addr_b  = r.addr_a | half;
        r.twiddle = TW'((kk & mask) << tw_shift);
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fft_bfly_addrgen.sv
`default_nettype none
// ============================================================================
// fft_bfly_addrgen : combinational (k, stage) -> butterfly RAM/twiddle addresses.
// Revision         : 1.0
// ============================================================================
module fft_bfly_addrgen
#(
    parameter int LOG2N = fft2048_pkg::LOG2N,
    parameter int AW    = LOG2N,
    parameter int TW    = LOG2N - 1,
    parameter int SW    = fft2048_pkg::SW
)
(
    input  logic [LOG2N-2:0] k,
    input  logic [SW-1:0]    s,
    output logic [AW-1:0]    addr_a,
    output logic [AW-1:0]    addr_b,
    output logic [TW-1:0]    twiddle_addr
);
    import fft2048_pkg::*;

    logic [AW-1:0] w_k_ext;
    logic [AW-1:0] w_half;
    logic [AW-1:0] w_mask;
    logic [SW-1:0] w_tw_shift;

    always_comb begin
        w_k_ext      = AW'(k);
        w_half       = AW'(1) << s;
        w_mask       = w_half - AW'(1);
        w_tw_shift   = SW'(LOG2N - 1) - s;
        addr_a       = (((w_k_ext >> s) << 1) << s) | (w_k_ext & w_mask);
        // bit s of addr_a is always zero, so OR never carries
        addr_b       = addr_a | w_half;
        twiddle_addr = TW'((w_k_ext & w_mask) << w_tw_shift);
    end

endmodule
`default_nettype wire

// File: rtl/fft_addresser2048.sv
`default_nettype none
// ============================================================================
// fft_addresser2048 : butterfly/stage counter and registered address outputs
//                     for the 2048-point FFT sequencer.
// Revision          : 1.0
// ============================================================================
module fft_addresser2048
#(
    parameter int LOG2N = fft2048_pkg::LOG2N,
    parameter int AW    = LOG2N,
    parameter int TW    = LOG2N - 1,
    parameter int SW    = fft2048_pkg::SW
)
(
    input  logic          clock,
    input  logic          reset,
    input  logic          addr_enable,
    input  logic          addr_writemode,
    input  logic          clear,
    output logic [AW-1:0] addr_a,
    output logic [AW-1:0] addr_b,
    output logic [TW-1:0] twiddle_addr,
    output logic          mem_we,
    output logic [SW-1:0] stage,
    output logic          last_butterfly,
    output logic          seq_wrap
);
    import fft2048_pkg::*;

    localparam int            c_kw     = LOG2N - 1;
    localparam logic [c_kw-1:0] c_k_last = {c_kw{1'b1}};
    localparam logic [SW-1:0]   c_s_last = SW'(LOG2N - 1);

    logic [c_kw-1:0] r_k;
    logic [SW-1:0]   r_s;
    logic [c_kw-1:0] w_k_next;
    logic [SW-1:0]   w_s_next;
    logic            w_wrap_next;

    logic [AW-1:0]   w_addr_a;
    logic [AW-1:0]   w_addr_b;
    logic [TW-1:0]   w_twiddle;

    logic [AW-1:0]   r_addr_a;
    logic [AW-1:0]   r_addr_b;
    logic [TW-1:0]   r_twiddle;
    logic [AW-1:0]   r_wr_addr_a;
    logic [AW-1:0]   r_wr_addr_b;
    logic [TW-1:0]   r_wr_twiddle;
    logic            r_mem_we;
    logic            r_seq_wrap;

    always_comb begin
        w_k_next    = r_k;
        w_s_next    = r_s;
        w_wrap_next = 1'b0;
        if (clear) begin
            w_k_next = '0;
            w_s_next = '0;
        end else if (addr_enable) begin
            if (r_k < c_k_last) begin
                w_k_next = r_k + 1'b1;
            end else begin
                w_k_next = '0;
                if (r_s < c_s_last) begin
                    w_s_next = r_s + 1'b1;
                end else begin
                    w_s_next    = '0;
                    w_wrap_next = 1'b1;
                end
            end
        end
    end

    // Addresses are computed from the next counter state so they land in
    // their registers on the same edge as k and s.
    fft_bfly_addrgen #(
        .LOG2N (LOG2N),
        .AW    (AW),
        .TW    (TW),
        .SW    (SW)
    ) u_addrgen (
        .k            (w_k_next),
        .s            (w_s_next),
        .addr_a       (w_addr_a),
        .addr_b       (w_addr_b),
        .twiddle_addr (w_twiddle)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_k          <= '0;
            r_s          <= '0;
            r_addr_a     <= '0;
            r_addr_b     <= AW'(1);
            r_twiddle    <= '0;
            r_wr_addr_a  <= '0;
            r_wr_addr_b  <= '0;
            r_wr_twiddle <= '0;
            r_mem_we     <= 1'b0;
            r_seq_wrap   <= 1'b0;
        end else begin
            r_k        <= w_k_next;
            r_s        <= w_s_next;
            r_addr_a   <= w_addr_a;
            r_addr_b   <= w_addr_b;
            r_twiddle  <= w_twiddle;
            r_mem_we   <= addr_writemode & ~clear;
            r_seq_wrap <= w_wrap_next;
            // snapshot of the pre-advance addresses for the write cycle
            if (addr_writemode) begin
                r_wr_addr_a  <= r_addr_a;
                r_wr_addr_b  <= r_addr_b;
                r_wr_twiddle <= r_twiddle;
            end
        end
    end

    assign addr_a         = r_mem_we ? r_wr_addr_a  : r_addr_a;
    assign addr_b         = r_mem_we ? r_wr_addr_b  : r_addr_b;
    assign twiddle_addr   = r_mem_we ? r_wr_twiddle : r_twiddle;
    assign mem_we         = r_mem_we;
    assign stage          = r_s;
    assign seq_wrap       = r_seq_wrap;
    assign last_butterfly = (r_k == c_k_last) && (r_s == c_s_last);

endmodule
`default_nettype wire

// File: doc/fft_addresser2048.md
Name: fft_addresser2048

Overview:
- Responder to the 2048-point FFT sequencer's `addr_enable` / `addr_writemode` strobes.
- Holds the current butterfly index and stage, and presents the RAM read/write address pair and the twiddle-ROM address for that butterfly.
- Advances one butterfly per `addr_enable` pulse through 11 radix-2 DIT stages of 1024 butterflies each: 11264 butterflies per transform.
- Generates the data-RAM write strobe from `addr_writemode`. Sits between the sequencer and the sample RAM / twiddle ROM.

Parameters:
- LOG2N, 11, log2 of transform length; N = 2^LOG2N.
- AW, LOG2N, sample RAM address width.
- TW, LOG2N-1, twiddle ROM address width.
- SW, 4, stage counter width; must satisfy 2^SW > LOG2N.

Ports:
- clock  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- addr_enable  in  1  single-cycle pulse; advance to next butterfly.
- addr_writemode  in  1  single-cycle pulse; write butterfly results to current addresses.
- clear  in  1  synchronous restart of address sequence without full reset.
- addr_a  out  AW  RAM address of butterfly upper input/output.
- addr_b  out  AW  RAM address of butterfly lower input/output.
- twiddle_addr  out  TW  twiddle ROM index.
- mem_we  out  1  RAM write enable for both ports.
- stage  out  SW  current stage, 0..LOG2N-1.
- last_butterfly  out  1  high while pointing at stage LOG2N-1, k = N/2-1.
- seq_wrap  out  1  one-cycle pulse when the sequence wraps to stage 0, k 0.

Behaviour:
- State:
  - k: butterfly index, LOG2N-1 bits, 0..N/2-1.
  - s: stage, SW bits.
- Reset (reset=1): k=0, s=0, mem_we=0, seq_wrap=0. addr_a=0, addr_b=1, twiddle_addr=0, stage=0, last_butterfly=0.
- Reset has priority over every other input, including mid-sequence. The next butterfly after reset deasserts is stage 0, k 0.
- clear=1 (reset low): same effect as reset on k, s, mem_we, seq_wrap. Overrides addr_enable in the same cycle.
- Address arithmetic, all registered from k and s and valid the cycle after k/s update:
  - half = 2^s.
  - addr_a = ((k >> s) << (s+1)) | (k & (half-1)).
  - addr_b = addr_a | half. This never carries, because bit s of addr_a is 0.
  - twiddle_addr = (k & (half-1)) << (LOG2N-1-s), truncated to TW bits.
  - All shifts are logical, with no sign extension.
- Advance: on a cycle with addr_enable=1:
  - If k < N/2-1: k <= k+1.
  - Else if s < LOG2N-1: k <= 0, s <= s+1.
  - Else (last butterfly): k <= 0, s <= 0, seq_wrap <= 1 for exactly the next cycle.
- Latency: addresses and `stage` reflect the advance 1 cycle after the `addr_enable` pulse. The sequencer re-reads them no earlier than 1 cycle later, so no stall signal is needed.
- mem_we is registered: mem_we = addr_writemode delayed one cycle, width 1 cycle. The addresses are guaranteed not to have changed, because advance occurs only on a later `addr_enable`.
- Simultaneous addr_writemode and addr_enable:
  - mem_we still asserts next cycle.
  - The write must target the pre-advance addresses. Keep a registered copy of addr_a/addr_b/twiddle_addr (`wr_addr_*`) and drive the outputs from it during the mem_we cycle.
  - Normal operation never produces this case.
- Back-to-back addr_enable on consecutive cycles: each pulse advances once; no pulse is dropped.
- addr_enable held high: advances every cycle.
- last_butterfly is combinational from the k and s registers.
- Width rules:
  - k wraps only by explicit compare, never by overflow.
  - s is never allowed to reach LOG2N.

Decomposition:
- Shared package `fft2048_pkg`:
  - Constants LOG2N=11, N=2048, NBFLY=N/2, NSTAGE=11, TOTAL_BFLY=11264.
  - Address, twiddle and stage width localparams.
  - A function `bfly_addr(k,s)` returning {addr_a, addr_b, twiddle_addr}.
- One natural sub-module `fft_bfly_addrgen`: purely combinational (k,s) -> address triplet, reusable by a future inverse-FFT addresser. The counters and registers stay in the top.

Test Plan:
- Reset released -> addr_a=0, addr_b=1, twiddle_addr=0, stage=0, mem_we=0, last_butterfly=0.
- 1 addr_enable -> addr_a=2, addr_b=3; 1023 total -> addr_a=2046, addr_b=2047, stage=0.
- 1024 addr_enable -> stage=1, addr_a=0, addr_b=2, tw=0; next -> addr_a=1, addr_b=3, tw=512.
- 10240+5 addr_enable -> stage=10, addr_a=5, addr_b=1029, tw=5. Continue to 11263 -> addr_a=1023, addr_b=2047, tw=1023, last_butterfly=1.
- 11264th addr_enable -> seq_wrap pulses 1 cycle; stage=0, addr_a=0, addr_b=1.
- addr_writemode pulse (alone, then coincident with addr_enable) -> mem_we high exactly 1 cycle at pre-advance addresses. clear or reset mid-stage 5 -> back to stage 0, k 0, mem_we=0.
